// File: rtl/pred_block_collector_pkg.sv
// Shared constants and types for the prediction block collector.
// Bank states and rounding helpers used by the top and the lane units.
package pred_block_collector_pkg;

  localparam int SAMPLE_W  = 14;
  localparam int PIXEL_W   = 8;
  localparam int SHIFT     = 6;
  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int ROUND_OFS = 1 << (SHIFT - 1);

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

  function automatic int round_ofs(input int sh);
    return 1 << (sh - 1);
  endfunction

endpackage

// File: rtl/pred_round_clip.sv
// One interpolator lane: round-half-up shift, then clip to pixel range.
// Purely combinational so the row lands in the bank with no extra latency.
module pred_round_clip #(
  parameter int SAMPLE_W = pred_block_collector_pkg::SAMPLE_W,
  parameter int PIXEL_W  = pred_block_collector_pkg::PIXEL_W,
  parameter int SHIFT    = pred_block_collector_pkg::SHIFT
) (
  input  logic [SAMPLE_W-1:0] sample_i,
  output logic [PIXEL_W-1:0]  pixel_o
);
  import pred_block_collector_pkg::*;

  localparam logic signed [SAMPLE_W:0] OFS =
    (SAMPLE_W+1)'(round_ofs(SHIFT));
  localparam logic signed [SAMPLE_W:0] PMAX =
    (SAMPLE_W+1)'((1 << PIXEL_W) - 1);

  logic signed [SAMPLE_W:0] sum;
  logic signed [SAMPLE_W:0] shd;

  assign sum = $signed({sample_i[SAMPLE_W-1], sample_i}) + OFS;
  assign shd = sum >>> SHIFT;

  // Clip the shifted value into [0, 2^PIXEL_W-1]
  always_comb begin
    unique case (1'b1)
      shd[SAMPLE_W]: pixel_o = '0;
      (shd > PMAX):  pixel_o = '1;
      default:       pixel_o = shd[PIXEL_W-1:0];
    endcase
  end

endmodule

// File: rtl/pred_block_collector.sv
// Collects rounded interpolator rows into 4x4 blocks, ping-pong banked.
// The producer never stalls: rows arriving with both banks full are dropped.
module pred_block_collector #(
  parameter int SAMPLE_W = pred_block_collector_pkg::SAMPLE_W,
  parameter int PIXEL_W  = pred_block_collector_pkg::PIXEL_W,
  parameter int SHIFT    = pred_block_collector_pkg::SHIFT,
  parameter int ROWS     = pred_block_collector_pkg::ROWS
) (
  input  logic                      CLK,
  input  logic                      RST_ASYNC_N,
  input  logic                      START,
  input  logic                      IN_VALID,
  input  logic [SAMPLE_W-1:0]       IN_SAMPLE_0,
  input  logic [SAMPLE_W-1:0]       IN_SAMPLE_1,
  input  logic [SAMPLE_W-1:0]       IN_SAMPLE_2,
  input  logic [SAMPLE_W-1:0]       IN_SAMPLE_3,
  input  logic                      DONE_ALL,
  output logic                      OUT_VALID,
  input  logic                      OUT_READY,
  output logic [ROWS*4*PIXEL_W-1:0] OUT_BLOCK,
  output logic [7:0]                OUT_BLOCK_IDX,
  output logic                      OUT_LAST,
  output logic                      OVERFLOW
);
  import pred_block_collector_pkg::*;

  localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int ROW_W = COLS * PIXEL_W;
  localparam int BLK_W = ROWS * ROW_W;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  logic [SAMPLE_W-1:0] lane [COLS];
  logic [ROW_W-1:0]    row_pix;

  bank_state_e      st_q   [2];
  bank_state_e      st_d   [2];
  logic [BLK_W-1:0] mem_q  [2];
  logic [BLK_W-1:0] mem_d  [2];
  logic [7:0]       idx_q  [2];
  logic [7:0]       idx_d  [2];
  logic [1:0]       last_q, last_d;
  logic             wb_q, wb_d;
  logic             rb_q, rb_d;
  logic [RW-1:0]    row_q, row_d;
  logic [7:0]       blk_q, blk_d;
  logic             ovf_q, ovf_d;
  logic             hs;
  logic             close;

  assign lane[0] = IN_SAMPLE_0;
  assign lane[1] = IN_SAMPLE_1;
  assign lane[2] = IN_SAMPLE_2;
  assign lane[3] = IN_SAMPLE_3;

  for (genvar c = 0; c < COLS; c++) begin : g_lane
    pred_round_clip #(
      .SAMPLE_W(SAMPLE_W),
      .PIXEL_W (PIXEL_W),
      .SHIFT   (SHIFT)
    ) u_rc (
      .sample_i(lane[c]),
      .pixel_o (row_pix[c*PIXEL_W +: PIXEL_W])
    );
  end

  // State register: banks, pointers, counters, sticky overflow
  always_ff @(posedge CLK or negedge RST_ASYNC_N) begin
    if (!RST_ASYNC_N) begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= EMPTY;
        mem_q[b] <= '0;
        idx_q[b] <= '0;
      end
      last_q <= '0;
      wb_q   <= 1'b0;
      rb_q   <= 1'b0;
      row_q  <= '0;
      blk_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        st_q[b]  <= st_d[b];
        mem_q[b] <= mem_d[b];
        idx_q[b] <= idx_d[b];
      end
      last_q <= last_d;
      wb_q   <= wb_d;
      rb_q   <= rb_d;
      row_q  <= row_d;
      blk_q  <= blk_d;
      ovf_q  <= ovf_d;
    end
  end

  // Next state: drain, write row, then apply end-of-CU rules
  always_comb begin
    st_d   = st_q;
    mem_d  = mem_q;
    idx_d  = idx_q;
    last_d = last_q;
    wb_d   = wb_q;
    rb_d   = rb_q;
    row_d  = row_q;
    blk_d  = blk_q;
    ovf_d  = ovf_q;
    close  = 1'b0;
    if (START) begin
      for (int b = 0; b < 2; b++) begin
        st_d[b]  = EMPTY;
        mem_d[b] = '0;
        idx_d[b] = '0;
      end
      last_d = '0;
      wb_d   = 1'b0;
      rb_d   = 1'b0;
      row_d  = '0;
      blk_d  = '0;
      ovf_d  = 1'b0;
    end else begin
      if (hs) begin
        st_d[rb_q] = EMPTY;
        rb_d       = ~rb_q;
      end
      if (IN_VALID) begin
        if (st_q[wb_q] == FULL) begin
          ovf_d = 1'b1;
        end else begin
          mem_d[wb_q][row_q*ROW_W +: ROW_W] = row_pix;
          st_d[wb_q] = FILLING;
          if (row_q == LAST_ROW) close = 1'b1;
          else                   row_d = row_q + RW'(1);
        end
      end
      if (DONE_ALL && !close) begin
        if (row_d != '0) begin
          for (int r = 0; r < ROWS; r++) begin
            if (r >= int'(row_d))
              mem_d[wb_q][r*ROW_W +: ROW_W] = '0;
          end
          close = 1'b1;
        end else if (st_d[~wb_q] == FULL) begin
          last_d[~wb_q] = 1'b1;
        end
      end
      if (close) begin
        st_d[wb_q]   = FULL;
        idx_d[wb_q]  = blk_q;
        last_d[wb_q] = DONE_ALL;
        row_d        = '0;
        wb_d         = ~wb_q;
        blk_d        = blk_q + 8'd1;
      end
    end
  end

  // Outputs: present the read bank, flag handshake
  always_comb begin
    OUT_VALID     = (st_q[rb_q] == FULL);
    OUT_BLOCK     = mem_q[rb_q];
    OUT_BLOCK_IDX = idx_q[rb_q];
    OUT_LAST      = last_q[rb_q];
    OVERFLOW      = ovf_q;
    hs            = OUT_VALID & OUT_READY;
  end

endmodule

// File: tb/tb_pred_block_collector.sv
// Directed bench for pred_block_collector.
// Cycle vector table plus hand sequences for async reset and high clip.
module tb_pred_block_collector;

  localparam logic [13:0] SA = 14'h0800;
  localparam logic [13:0] SC = 14'h0400;
  localparam logic [13:0] SD = 14'h0C00;
  localparam logic [13:0] SE = 14'h1000;
  localparam logic [55:0] RB =
    {14'd8191, 14'd32, 14'd31, 14'h3F00};

  localparam logic [127:0] BA   = {16{8'h20}};
  localparam logic [127:0] BB   = {4{8'd128, 8'd1, 8'd0, 8'd0}};
  localparam logic [127:0] BC   = {16{8'h10}};
  localparam logic [127:0] BD   = {16{8'h30}};
  localparam logic [127:0] BPAD = {{8{8'h00}}, {8{8'h20}}};
  localparam logic [127:0] BC3D = {{4{8'h30}}, {12{8'h10}}};

  typedef struct {
    logic         iv;
    logic [55:0]  s;
    logic         done;
    logic         rdy;
    logic         st;
    logic         ev;
    logic [7:0]   idx;
    logic         last;
    logic         ovf;
    logic [127:0] blk;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         iv = 1'b0;
  logic [13:0]  s0 = '0, s1 = '0, s2 = '0, s3 = '0;
  logic         done = 1'b0;
  logic         rdy = 1'b0;
  logic         ov, olast, oovf;
  logic [127:0] oblk;
  logic [7:0]   oidx;
  logic         ov4, olast4, oovf4;
  logic [127:0] oblk4;
  logic [7:0]   oidx4;

  int nchk = 0;
  int nerr = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  pred_block_collector dut (
    .CLK(clk), .RST_ASYNC_N(rst_n), .START(start),
    .IN_VALID(iv), .IN_SAMPLE_0(s0), .IN_SAMPLE_1(s1),
    .IN_SAMPLE_2(s2), .IN_SAMPLE_3(s3), .DONE_ALL(done),
    .OUT_VALID(ov), .OUT_READY(rdy), .OUT_BLOCK(oblk),
    .OUT_BLOCK_IDX(oidx), .OUT_LAST(olast), .OVERFLOW(oovf)
  );

  pred_block_collector #(.SHIFT(4)) dut4 (
    .CLK(clk), .RST_ASYNC_N(rst_n), .START(start),
    .IN_VALID(iv), .IN_SAMPLE_0(s0), .IN_SAMPLE_1(s1),
    .IN_SAMPLE_2(s2), .IN_SAMPLE_3(s3), .DONE_ALL(done),
    .OUT_VALID(ov4), .OUT_READY(rdy), .OUT_BLOCK(oblk4),
    .OUT_BLOCK_IDX(oidx4), .OUT_LAST(olast4), .OVERFLOW(oovf4)
  );

  function automatic logic [55:0] rw(input logic [13:0] x);
    return {4{x}};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic add(input logic a_iv, input logic [55:0] a_s,
                     input logic a_done, input logic a_rdy,
                     input logic a_st, input logic a_ev,
                     input logic [7:0] a_idx, input logic a_last,
                     input logic a_ovf, input logic [127:0] a_blk);
    vec_t v;
    v.iv = a_iv; v.s = a_s; v.done = a_done; v.rdy = a_rdy;
    v.st = a_st; v.ev = a_ev; v.idx = a_idx; v.last = a_last;
    v.ovf = a_ovf; v.blk = a_blk;
    vq.push_back(v);
  endtask

  task automatic cyc(input logic a_iv, input logic [55:0] a_s,
                     input logic a_rdy);
    iv = a_iv;
    {s3, s2, s1, s0} = a_s;
    rdy = a_rdy;
    done = 1'b0;
    start = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_valid", 128'(ov), 128'(0));
    chk("rst_block", oblk, 128'(0));
    chk("rst_idx", 128'(oidx), 128'(0));
    chk("rst_last", 128'(olast), 128'(0));
    chk("rst_ovf", 128'(oovf), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: basic block, ready high
    for (int i = 0; i < 3; i++) add(1, rw(SA), 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, rw(SA), 0, 1, 0, 1, 0, 0, 0, BA);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // 2: rounding and low clip
    for (int i = 0; i < 3; i++) add(1, RB, 0, 1, 0, 0, 0, 0, 0, 0);
    add(1, RB, 0, 1, 0, 1, 1, 0, 0, BB);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
    // 3: both banks full, ninth row dropped
    for (int i = 0; i < 3; i++) add(1, rw(SC), 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, rw(SC), 0, 0, 0, 1, 2, 0, 0, BC);
    for (int i = 0; i < 4; i++) add(1, rw(SD), 0, 0, 0, 1, 2, 0, 0, BC);
    add(1, rw(SE), 0, 0, 0, 1, 2, 0, 1, BC);
    add(0, 0, 0, 1, 0, 1, 3, 0, 1, BD);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // 4: completion and handshake in same cycle, no bubble
    for (int i = 0; i < 3; i++) add(1, rw(SA), 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, rw(SA), 0, 0, 0, 1, 4, 0, 1, BA);
    for (int i = 0; i < 3; i++) add(1, rw(SC), 0, 0, 0, 1, 4, 0, 1, BA);
    add(1, rw(SC), 0, 1, 0, 1, 5, 0, 1, BC);
    for (int i = 0; i < 3; i++) add(1, rw(SD), 0, 0, 0, 1, 5, 0, 1, BC);
    add(1, rw(SD), 0, 1, 0, 1, 6, 0, 1, BD);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // 5: partial block padded, empty DONE, DONE with row, DONE on full
    for (int i = 0; i < 2; i++) add(1, rw(SA), 0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 1, 7, 1, 1, BPAD);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, rw(SC), 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, rw(SD), 1, 0, 0, 1, 8, 1, 1, BC3D);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(1, rw(SA), 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, rw(SA), 0, 0, 0, 1, 9, 0, 1, BA);
    add(0, 0, 1, 0, 0, 1, 9, 1, 1, BA);
    add(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);
    // 6b: START mid-block clears everything
    for (int i = 0; i < 2; i++) add(1, rw(SC), 0, 0, 0, 0, 0, 0, 1, 0);
    add(1, rw(SC), 1, 1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) add(1, rw(SA), 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, rw(SA), 0, 0, 0, 1, 0, 0, 0, BA);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0);

    foreach (vq[k]) begin
      iv = vq[k].iv;
      {s3, s2, s1, s0} = vq[k].s;
      done = vq[k].done;
      rdy = vq[k].rdy;
      start = vq[k].st;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", k), 128'(ov), 128'(vq[k].ev));
      chk($sformatf("v%0d_ovf", k), 128'(oovf), 128'(vq[k].ovf));
      if (vq[k].ev) begin
        chk($sformatf("v%0d_idx", k), 128'(oidx), 128'(vq[k].idx));
        chk($sformatf("v%0d_last", k), 128'(olast), 128'(vq[k].last));
        chk($sformatf("v%0d_blk", k), oblk, vq[k].blk);
      end
    end

    // 6a: async reset with a full block pending and a partial block
    for (int i = 0; i < 4; i++) cyc(1, rw(SC), 0);
    chk("pre_rst_valid", 128'(ov), 128'(1));
    chk("pre_rst_idx", 128'(oidx), 128'(1));
    for (int i = 0; i < 3; i++) cyc(1, rw(SD), 0);
    iv = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(ov), 128'(0));
    chk("arst_block", oblk, 128'(0));
    chk("arst_idx", 128'(oidx), 128'(0));
    chk("arst_ovf", 128'(oovf), 128'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(1, rw(SA), 0);
    chk("post_rst_early", 128'(ov), 128'(0));
    cyc(1, rw(SA), 0);
    chk("post_rst_valid", 128'(ov), 128'(1));
    chk("post_rst_idx", 128'(oidx), 128'(0));
    chk("post_rst_blk", oblk, BA);

    // 2b: high clip with SHIFT=4, nominal with SHIFT=6
    cyc(1, rw(SE), 1);
    for (int i = 0; i < 3; i++) cyc(1, rw(SE), 0);
    chk("clip6_valid", 128'(ov), 128'(1));
    chk("clip6_blk", oblk, {16{8'h40}});
    chk("clip4_valid", 128'(ov4), 128'(1));
    chk("clip4_blk", oblk4, {16{8'hFF}});
    chk("clip4_idx", 128'(oidx4), 128'(1));
    chk("clip4_last", 128'(olast4), 128'(0));
    chk("clip4_ovf", 128'(oovf4), 128'(0));
    cyc(0, 0, 1);
    chk("final_valid", 128'(ov), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
